// File: rtl/verdict_pkg.sv
// Shared constants, the default-width verdict record and the overflow helper for
// monitor_verdict_buffer.
package verdict_pkg;

  localparam int NUM_OUTPUTS_DEF = 3;
  localparam int DATA_W_DEF      = 64;
  localparam int TS_W_DEF        = 32;
  localparam int DEPTH_DEF       = 16;
  localparam int OVF_W           = 16;

  // Record layout at default widths; the top mirrors this layout for its own parameters.
  typedef struct packed {
    logic [TS_W_DEF-1:0]                ts;
    logic [NUM_OUTPUTS_DEF-1:0]         mask;
    logic [NUM_OUTPUTS_DEF*DATA_W_DEF-1:0] data;
  } verdict_rec_t;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + OVF_W'(1);
  endfunction

endpackage

// File: rtl/monitor_verdict_buffer_if.sv
// Monitor-side capture inputs and host-side record stream of monitor_verdict_buffer.
// master = the buffer itself, slave = the environment (monitor plus record consumer).
interface monitor_verdict_buffer_if #(
  parameter int NUM_OUTPUTS = verdict_pkg::NUM_OUTPUTS_DEF,
  parameter int DATA_W      = verdict_pkg::DATA_W_DEF,
  parameter int TS_W        = verdict_pkg::TS_W_DEF,
  parameter int DEPTH       = verdict_pkg::DEPTH_DEF
);
  import verdict_pkg::*;

  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic                          en;
  logic [NUM_OUTPUTS*DATA_W-1:0] mon_data;
  logic [NUM_OUTPUTS-1:0]        mon_aktv;

  logic                          rec_valid;
  logic                          rec_ready;
  logic [TS_W-1:0]               rec_ts;
  logic [NUM_OUTPUTS-1:0]        rec_mask;
  logic [NUM_OUTPUTS*DATA_W-1:0] rec_data;

  logic [FILL_W-1:0]             fill;
  logic [OVF_W-1:0]              ovf_cnt;

  modport master (
    input  en, mon_data, mon_aktv, rec_ready,
    output rec_valid, rec_ts, rec_mask, rec_data, fill, ovf_cnt
  );

  modport slave (
    output en, mon_data, mon_aktv, rec_ready,
    input  rec_valid, rec_ts, rec_mask, rec_data, fill, ovf_cnt
  );

endinterface

// File: rtl/verdict_fifo.sv
// Generic synchronous FIFO with the head entry held in an output register; an entry
// pushed into an empty FIFO reaches the head register on the next non-held edge.
module verdict_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  ONE      = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_vld_q, head_vld_d;
  logic             mem_empty;
  logic             load;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  // The head register refills from storage whenever it is empty or being consumed.
  assign load      = ~hold & ~mem_empty & (~head_vld_q | pop);

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    head_d     = head_q;
    head_vld_d = head_vld_q;

    if (push) wr_ptr_d = wr_ptr_q + ONE;

    if (load) begin
      head_d     = mem_q[rd_ptr_q[PTR_W-1:0]];
      head_vld_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + ONE;
    end else if (pop) begin
      head_vld_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  assign rdata  = head_q;
  assign rvalid = head_vld_q;
  assign count  = count_q;
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);

endmodule

// File: rtl/monitor_verdict_buffer.sv
// Captures RTLola monitor verdicts into timestamped records and streams them out.
// Define VERDICT_BUFFER_OVF_CNT_EN to implement the saturating dropped-record counter.
module monitor_verdict_buffer #(
  parameter int NUM_OUTPUTS = verdict_pkg::NUM_OUTPUTS_DEF,
  parameter int DATA_W      = verdict_pkg::DATA_W_DEF,
  parameter int TS_W        = verdict_pkg::TS_W_DEF,
  parameter int DEPTH       = verdict_pkg::DEPTH_DEF
) (
  input logic                      clk,
  input logic                      rst,
  monitor_verdict_buffer_if.master bus
);
  import verdict_pkg::*;

  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam int VAL_W  = NUM_OUTPUTS * DATA_W;

  typedef struct packed {
    logic [TS_W-1:0]        ts;
    logic [NUM_OUTPUTS-1:0] mask;
    logic [VAL_W-1:0]       data;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic              capture;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  logic              head_vld;
  logic [FILL_W-1:0] count;
  rec_t              rec_in;
  rec_t              rec_out;

  // The stored timestamp is the pre-increment value of the capturing cycle.
  always_comb begin
    rec_in      = '0;
    rec_in.ts   = ts_q;
    rec_in.mask = bus.mon_aktv;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      rec_in.data[k*DATA_W +: DATA_W] =
        bus.mon_aktv[k] ? bus.mon_data[k*DATA_W +: DATA_W] : '0;
    end
  end

  assign capture = bus.en & (|bus.mon_aktv);
  assign pop     = bus.en & head_vld & bus.rec_ready & ~empty;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign push    = capture & (~full | pop);

  always_comb begin
    ts_d = ts_q;
    if (bus.en) ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_d;
  end

  verdict_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .hold   (~bus.en),
    .push   (push),
    .wdata  (rec_in),
    .pop    (pop),
    .rdata  (rec_out),
    .rvalid (head_vld),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign bus.rec_valid = head_vld;
  assign bus.rec_ts    = rec_out.ts;
  assign bus.rec_mask  = rec_out.mask;
  assign bus.rec_data  = rec_out.data;
  assign bus.fill      = count;

`ifdef VERDICT_BUFFER_OVF_CNT_EN
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             drop;

  assign drop = capture & full & ~pop;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) ovf_cnt_d = sat_inc(ovf_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`else
  assign bus.ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_monitor_verdict_buffer.sv
// Self-checking bench for monitor_verdict_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_monitor_verdict_buffer;
  import verdict_pkg::*;

  localparam int N     = NUM_OUTPUTS_DEF;
  localparam int DW    = DATA_W_DEF;
  localparam int TW    = TS_W_DEF;
  localparam int DEPTH = DEPTH_DEF;

`ifdef VERDICT_BUFFER_OVF_CNT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  monitor_verdict_buffer_if #(
    .NUM_OUTPUTS (N), .DATA_W (DW), .TS_W (TW), .DEPTH (DEPTH)
  ) bus ();

  monitor_verdict_buffer #(
    .NUM_OUTPUTS (N), .DATA_W (DW), .TS_W (TW), .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of buffered records; a record may be presented only
  // once it has been in the buffer across at least one enabled edge.
  typedef struct {
    verdict_rec_t rec;
    bit           aged;
  } entry_t;

  entry_t          mq[$];
  int unsigned     m_ovf = 0;
  logic [TW-1:0]   m_ts  = '0;

  function automatic bit m_valid();
    return (mq.size() > 0) && mq[0].aged;
  endfunction

  always @(posedge clk) begin : model
    entry_t e;
    if (!rst) begin
      mq.delete();
      m_ovf = 0;
      m_ts  = '0;
    end else if (bus.en) begin
      if (m_valid() && bus.rec_ready) void'(mq.pop_front());
      for (int i = 0; i < mq.size(); i++) mq[i].aged = 1'b1;
      if (|bus.mon_aktv) begin
        if (mq.size() < DEPTH) begin
          e.aged     = 1'b0;
          e.rec.ts   = m_ts;
          e.rec.mask = bus.mon_aktv;
          for (int k = 0; k < N; k++)
            e.rec.data[k*DW +: DW] = bus.mon_aktv[k] ? bus.mon_data[k*DW +: DW] : '0;
          mq.push_back(e);
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
      end
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_valid", bus.rec_valid, m_valid());
      check("cmp_fill", bus.fill, mq.size());
      check("cmp_ovf", bus.ovf_cnt, OVF_ON ? m_ovf : 0);
      if (m_valid()) begin
        check("cmp_ts", bus.rec_ts, mq[0].rec.ts);
        check("cmp_mask", bus.rec_mask, mq[0].rec.mask);
        check("cmp_data", bus.rec_data, mq[0].rec.data);
      end
    end
  end

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int k = 0; k < N*DW/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [N-1:0] rnd_aktv_nz();
    return N'($urandom_range(1, (1 << N) - 1));
  endfunction

  task automatic cyc(input bit en, input logic [N-1:0] aktv, input logic [N*DW-1:0] data,
                     input bit ready);
    bus.en        = en;
    bus.mon_aktv  = aktv;
    bus.mon_data  = data;
    bus.rec_ready = ready;
    @(posedge clk);
    #1;
  endtask

  logic [N*DW-1:0] d_in;
  logic [N*DW-1:0] d_exp;
  logic [TW-1:0]   popped[$];
  int              ready_pct;

  initial begin
    bus.en = 1'b0; bus.mon_aktv = '0; bus.mon_data = '0; bus.rec_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_valid", bus.rec_valid, 0);
    check("rst_fill", bus.fill, 0);
    check("rst_ovf", bus.ovf_cnt, 0);
    check("rst_ts", bus.rec_ts, 0);
    check("rst_mask", bus.rec_mask, 0);
    check("rst_data", bus.rec_data, 0);
    rst = 1'b1;

    // Idle, then a single capture on the eleventh enabled cycle (ts = 10).
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, '0, '0, 1'b1);
      if (i == 4) begin
        check("idle_valid", bus.rec_valid, 0);
        check("idle_fill", bus.fill, 0);
        check("idle_ovf", bus.ovf_cnt, 0);
        check("idle_data", bus.rec_data, 0);
      end
    end
    d_in  = {64'd1, 64'd9, 64'd1};
    d_exp = {64'd1, 64'd0, 64'd1};
    cyc(1'b1, 3'b101, d_in, 1'b1);
    check("cap_fill", bus.fill, 1);
    check("cap_valid_early", bus.rec_valid, 0);
    cyc(1'b1, '0, '0, 1'b1);
    check("cap_valid", bus.rec_valid, 1);
    check("cap_mask", bus.rec_mask, 3'b101);
    check("cap_data", bus.rec_data, d_exp);
    check("cap_ts", bus.rec_ts, 10);
    cyc(1'b1, '0, '0, 1'b1);
    check("cap_popped_valid", bus.rec_valid, 0);
    check("cap_popped_fill", bus.fill, 0);

    // 20 captures into a stalled 16-deep buffer: ts 13..28 kept, 29..32 dropped.
    for (int i = 0; i < 20; i++) cyc(1'b1, rnd_aktv_nz(), rnd_data(), 1'b0);
    check("burst_fill", bus.fill, 16);
    check("burst_ovf", bus.ovf_cnt, OVF_ON ? 4 : 0);
    check("burst_head_ts", bus.rec_ts, 13);

    // Full with pop and capture together: accepted, no drop.
    cyc(1'b1, rnd_aktv_nz(), rnd_data(), 1'b1);
    check("fullpop_fill", bus.fill, 16);
    check("fullpop_ovf", bus.ovf_cnt, OVF_ON ? 4 : 0);
    check("fullpop_head_ts", bus.rec_ts, 14);

    for (int i = 0; i < 18; i++) begin
      if (bus.rec_valid) popped.push_back(bus.rec_ts);
      cyc(1'b1, '0, '0, 1'b1);
    end
    check("drain_count", popped.size(), 16);
    if (popped.size() == 16) begin
      for (int i = 0; i < 15; i++) check("drain_ts_seq", popped[i], 14 + i);
      check("drain_last_ts", popped[15], 33);
    end

    // Reset mid-operation with five records buffered and a capture pending.
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd_aktv_nz(), rnd_data(), 1'b0);
    check("prerst_fill", bus.fill, 5);
    rst = 1'b0;
    cyc(1'b1, 3'b111, rnd_data(), 1'b1);
    check("midrst_fill", bus.fill, 0);
    check("midrst_valid", bus.rec_valid, 0);
    check("midrst_ovf", bus.ovf_cnt, 0);
    rst = 1'b1;

    // Captures at ts 3 and ts 4 separated by disabled cycles.
    for (int i = 0; i < 3; i++) cyc(1'b1, '0, '0, 1'b0);
    cyc(1'b1, rnd_aktv_nz(), rnd_data(), 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, rnd_aktv_nz(), rnd_data(), 1'($urandom_range(0, 1)));
      check("en0_fill", bus.fill, 1);
      check("en0_valid", bus.rec_valid, 0);
    end
    cyc(1'b1, rnd_aktv_nz(), rnd_data(), 1'b0);
    check("en_ts3_valid", bus.rec_valid, 1);
    check("en_ts3", bus.rec_ts, 3);
    check("en_ts3_fill", bus.fill, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, rnd_aktv_nz(), rnd_data(), 1'b1);
      check("en0_hold_ts", bus.rec_ts, 3);
      check("en0_hold_fill", bus.fill, 2);
    end
    cyc(1'b1, '0, '0, 1'b1);
    check("en_ts4", bus.rec_ts, 4);
    check("en_ts4_fill", bus.fill, 1);
    cyc(1'b1, '0, '0, 1'b1);
    check("en_end_valid", bus.rec_valid, 0);

    // Randomized traffic with varying consumer pressure and rare resets.
    for (int i = 0; i < 2400; i++) begin
      if (i % 200 == 0) ready_pct = (i / 200 % 3 == 0) ? 10 : (i / 200 % 3 == 1) ? 50 : 90;
      rst = ($urandom_range(0, 299) != 0);
      cyc($urandom_range(0, 99) < 85,
          ($urandom_range(0, 9) < 4) ? '0 : N'($urandom()),
          rnd_data(),
          $urandom_range(0, 99) < ready_pct);
    end
    rst = 1'b1;
    repeat (3) cyc(1'b1, '0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/monitor_verdict_buffer.md
# monitor_verdict_buffer

Downstream consumer of the RTLola monitor (`topEntity`). Each cycle in which at least one `output_k_aktv` is high, the block captures all output values, the active mask and a cycle timestamp into a record. Records are buffered in a synchronous FIFO and drained over a valid/ready stream toward the host or trace link. Full-FIFO overflow is handled by counted drops, so the monitor is never back-pressured.

## Interface
Parameters:
- `NUM_OUTPUTS`, default 3: number of monitor output streams.
- `DATA_W`, default 64: width of each signed output value.
- `TS_W`, default 32: timestamp width.
- `DEPTH`, default 16: FIFO depth in records; must be a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `en`  in  1  global enable, same semantics as the monitor's `en`.
- `mon_data`  in  NUM_OUTPUTS*DATA_W  monitor outputs, concatenated; output 0 in the LSBs.
- `mon_aktv`  in  NUM_OUTPUTS  per-output active flags; bit k = `output_k_aktv`.
- `rec_valid`  out  1  a head record is presented.
- `rec_ready`  in  1  consumer accepts the head record.
- `rec_ts`  out  TS_W  timestamp of the head record.
- `rec_mask`  out  NUM_OUTPUTS  active mask of the head record.
- `rec_data`  out  NUM_OUTPUTS*DATA_W  values of the head record; inactive lanes read 0.
- `fill`  out  clog2(DEPTH)+1  current occupancy.
- `ovf_cnt`  out  16  dropped-record count, saturating.

## Operation
- Timestamp counter `ts`:
  - Increments by 1 on each cycle with `en`=1.
  - Wraps modulo 2^TS_W.
  - Frozen while `en`=0.
- Capture:
  - A capture event occurs on a cycle with `en`=1 and `|mon_aktv`.
  - The pushed record is {current `ts`, `mon_aktv`, `mon_data` with lanes where aktv=0 forced to 0}.
  - The `ts` value stored is the value before that cycle's increment.
- Drain:
  - A pop occurs on a cycle with `en`=1, `rec_valid`=1 and `rec_ready`=1.
  - The head record advances on the next edge.
- Full:
  - A capture while full with no simultaneous pop is dropped and `ovf_cnt` increments, saturating at 0xFFFF.
  - A capture while full with a simultaneous pop is accepted; occupancy stays at DEPTH.
- Empty: a simultaneous capture and pop cannot occur, because the pop requires `rec_valid`.
- `en`=0: no push, no pop, counters hold, outputs hold their values.
- Reset:
  - Outputs: `rec_valid`=0, `rec_ts`=0, `rec_mask`=0, `rec_data`=0, `fill`=0, `ovf_cnt`=0.
  - `ts` resets to 0 and read/write pointers clear.
  - A reset asserted mid-operation discards all buffered records and takes priority over push and pop.
- Values are treated as opaque bit vectors; there is no sign handling.

## Timing
- Capture at edge N: `rec_valid` rises after edge N+1 if the FIFO was empty, so capture-to-output latency is 1 cycle.
- Output registers (`rec_*`) are registered; there is no combinational path from `mon_*` to `rec_*`.
- `rec_valid` depends on `rec_ready` only through the registered pop.
- While `rec_valid`=1 and `rec_ready`=0, the `rec_*` outputs hold stable (AXI-stream rule).
- With back-to-back pops and continuous captures, throughput is 1 record per cycle.
- `fill` is updated on the same edge as the push or pop.
- `ovf_cnt` updates on the edge of the dropped capture.

## Configuration
- `VERDICT_BUFFER_OVF_CNT_EN` defined:
  - The overflow counter is implemented as described.
- `VERDICT_BUFFER_OVF_CNT_EN` undefined:
  - The counter logic is omitted and `ovf_cnt` is tied to 0.
  - Drops still occur silently with identical FIFO behaviour.

## Structure
- Package `verdict_pkg` holds:
  - Default constants `NUM_OUTPUTS_DEF`, `DATA_W_DEF`, `TS_W_DEF`.
  - The packed record typedef `verdict_rec_t` (ts, mask, data).
  - The `OVF_W`=16 constant.
- Sub-module `verdict_fifo`:
  - A generic synchronous FIFO with registered head output, parameterised by width and depth.
  - Provides `push`, `pop`, `full`, `empty` and `count`.
- The top level holds the timestamp counter, lane masking, drop logic and the overflow counter.

## Test plan
- Reset, then 5 idle cycles → `rec_valid`=0, `fill`=0, `ovf_cnt`=0; all `rec_*` outputs are 0.
- Single capture with `mon_aktv`=3'b101, data (1,9,1), 10 cycles after reset, `rec_ready`=1 → one cycle later: `rec_valid`=1, `rec_mask`=101, `rec_data` lanes (1,0,1), `rec_ts`=10. The record is popped on the next edge.
- `rec_ready`=0 and 20 consecutive captures with DEPTH=16 → `fill`=16 and `ovf_cnt`=4. Records then drain in order with `rec_ts` strictly increasing by 1.
- FIFO full, `rec_ready`=1 and a capture on the same cycle → `fill` stays 16 and `ovf_cnt` is unchanged.
- `en`=0 for 7 cycles between captures at ts 3 and ts 4 → the two records carry timestamps 3 and 4; outputs stay stable during `en`=0.
- Reset asserted with `fill`=5 → next cycle `fill`=0 and `rec_valid`=0; the next capture gets `rec_ts` equal to the cycles counted since reset release.
